// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter: FSM state encoding
// and the grant-index width helper.
package rr_grant_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   // Width of a binary index into n requesters (never narrower than 1 bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Pointer-relative one-hot pick: first set req bit at or above the one-hot
// ptr, wrapping from the top bit back to bit 0.
module rr_priority_pick #(
   parameter int unsigned NINPUTS = 4
) (
   input  logic [NINPUTS-1:0] req,
   input  logic [NINPUTS-1:0] ptr,
   output logic [NINPUTS-1:0] pick
);

   logic [NINPUTS-1:0] upper_req;
   logic [NINPUTS-1:0] upper_pick;
   logic [NINPUTS-1:0] lower_pick;

   // Requests at or above the pointer win first; otherwise wrap to the lowest.
   always_comb begin
      upper_req  = req & ~(ptr - NINPUTS'(1));
      upper_pick = upper_req & (~upper_req + NINPUTS'(1));
      lower_pick = req & (~req + NINPUTS'(1));
      pick       = (|upper_req) ? upper_pick : lower_pick;
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered, held one-hot grant and a
// valid/ready accept handshake; back-to-back grants on accept.
module rr_grant_arbiter
   import rr_grant_arbiter_pkg::*;
#(
   parameter int unsigned NINPUTS = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NINPUTS-1:0]                req,
   output logic [NINPUTS-1:0]                grant,
   output logic                              grant_valid,
   input  logic                              grant_ready,
   output logic [idx_width(NINPUTS)-1:0]     grant_idx
);

   localparam int unsigned IW = idx_width(NINPUTS);

   arb_state_t         state_q, state_d;
   logic [NINPUTS-1:0] ptr_q, ptr_d;
   logic [NINPUTS-1:0] grant_q, grant_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [NINPUTS-1:0] pick_ptr;
   logic [NINPUTS-1:0] pick;
   logic [IW-1:0]      pick_idx;

   // On accept the search starts just above the current winner.
   always_comb begin
      pick_ptr = ptr_q;
      if (state_q == HOLD) begin
         pick_ptr = {grant_q[NINPUTS-2:0], grant_q[NINPUTS-1]};
      end
   end

   rr_priority_pick #(
      .NINPUTS(NINPUTS)
   ) u_pick (
      .req (req),
      .ptr (pick_ptr),
      .pick(pick)
   );

   // Binary encode of the one-hot pick.
   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < NINPUTS; i++) begin
         if (pick[IW'(i)]) begin
            pick_idx = pick_idx | IW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = pick;
               idx_d   = pick_idx;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (grant_ready) begin
               ptr_d = pick_ptr;
               if (|req) begin
                  grant_d = pick;
                  idx_d   = pick_idx;
               end else begin
                  grant_d = '0;
                  idx_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= NINPUTS'(1);
         grant_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign grant_valid = (state_q == HOLD);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter (NINPUTS=4): directed vectors push
// expected outputs; a negedge monitor pops, compares and checks invariants.
module tb_rr_grant_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] grant;
   logic       grant_valid;
   logic       grant_ready;
   logic [1:0] grant_idx;

   typedef struct {
      int         cyc;
      logic       v;
      logic [3:0] g;
      logic [1:0] i;
      string      name;
   } exp_t;

   exp_t q[$];
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic       p_valid = 1'b0;
   logic       p_ready = 1'b0;
   logic       p_reset = 1'b1;
   logic [3:0] p_grant = '0;
   logic [1:0] p_idx   = '0;

   rr_grant_arbiter #(
      .NINPUTS(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .grant      (grant),
      .grant_valid(grant_valid),
      .grant_ready(grant_ready),
      .grant_idx  (grant_idx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
   endtask

   function automatic logic [1:0] enc(input logic [3:0] g);
      logic [1:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) if (g[k]) r = 2'(k);
      return r;
   endfunction

   // Monitor: scoreboard pop plus per-cycle invariants.
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         if (e.cyc < cyc) chk({"missed_", e.name}, 8'h00, 8'h01);
         else chk(e.name, {1'b0, grant_valid, grant, grant_idx}, {1'b0, e.v, e.g, e.i});
      end
      chk("onehot0", {7'd0, ($countones(grant) == (grant_valid ? 1 : 0))}, 8'd1);
      chk("idx_match", {6'd0, grant_idx}, {6'd0, enc(grant)});
      if (p_valid && !p_ready && !p_reset && grant_valid)
         chk("hold_stable", {2'd0, grant, grant_idx}, {2'd0, p_grant, p_idx});
      p_valid = grant_valid;
      p_ready = grant_ready;
      p_reset = reset;
      p_grant = grant;
      p_idx   = grant_idx;
   end

   // Apply inputs just after an edge; expectation holds after the next edge.
   task automatic step(input logic r, input logic [3:0] rq, input logic rd,
                       input logic ev, input logic [3:0] eg, input logic [1:0] ei,
                       input string nm);
      @(posedge clk);
      #1;
      reset       = r;
      req         = rq;
      grant_ready = rd;
      q.push_back('{cyc + 1, ev, eg, ei, nm});
   endtask

   initial begin
      reset       = 1'b1;
      req         = '0;
      grant_ready = 1'b0;

      step(1, 4'b0000, 0, 0, 4'b0000, 2'd0, "reset0");
      step(1, 4'b0101, 1, 0, 4'b0000, 2'd0, "reset1");
      // Hold with ready low
      step(0, 4'b0101, 0, 1, 4'b0001, 2'd0, "first_grant");
      for (int k = 0; k < 5; k++)
         step(0, 4'b0101, 0, 1, 4'b0001, 2'd0, "hold5");
      step(0, 4'b0101, 1, 1, 4'b0100, 2'd2, "accept_next");
      step(0, 4'b0000, 1, 0, 4'b0000, 2'd0, "accept_idle");
      // Pointer at bit 3: wrap-around
      step(0, 4'b0011, 0, 1, 4'b0001, 2'd0, "wrap");
      step(0, 4'b0000, 1, 0, 4'b0000, 2'd0, "wrap_idle");
      // Rotation from pointer 0 with all requesting
      step(1, 4'b0000, 0, 0, 4'b0000, 2'd0, "reset2");
      step(0, 4'b1111, 1, 1, 4'b0001, 2'd0, "rr0");
      step(0, 4'b1111, 1, 1, 4'b0010, 2'd1, "rr1");
      step(0, 4'b1111, 1, 1, 4'b0100, 2'd2, "rr2");
      step(0, 4'b1111, 1, 1, 4'b1000, 2'd3, "rr3");
      step(0, 4'b1111, 1, 1, 4'b0001, 2'd0, "rr4");
      step(0, 4'b1111, 1, 1, 4'b0010, 2'd1, "rr5");
      step(0, 4'b1111, 1, 1, 4'b0100, 2'd2, "rr6");
      // Winner drops req while held; no withdrawal
      for (int k = 0; k < 3; k++)
         step(0, 4'b0000, 0, 1, 4'b0100, 2'd2, "no_withdraw");
      step(0, 4'b0000, 1, 0, 4'b0000, 2'd0, "drop_idle");
      step(0, 4'b0011, 0, 1, 4'b0001, 2'd0, "wrap2");
      step(0, 4'b0000, 1, 0, 4'b0000, 2'd0, "wrap2_idle");
      // Sole requester is re-granted back-to-back
      step(0, 4'b0010, 0, 1, 4'b0010, 2'd1, "sole_grant");
      step(0, 4'b0010, 1, 1, 4'b0010, 2'd1, "sole_regrant");
      // Reset mid-HOLD drops the grant
      step(1, 4'b0010, 0, 0, 4'b0000, 2'd0, "reset_hold");
      step(0, 4'b0010, 0, 1, 4'b0010, 2'd1, "post_reset");
      step(0, 4'b0110, 1, 1, 4'b0100, 2'd2, "post_accept");
      step(0, 4'b0000, 1, 0, 4'b0000, 2'd0, "post_idle");
      // Pointer is bit 3 here; reset must bring it back to bit 0
      step(0, 4'b0100, 0, 1, 4'b0100, 2'd2, "pre_reset");
      step(1, 4'b1100, 1, 0, 4'b0000, 2'd0, "reset_ptr");
      step(0, 4'b1010, 0, 1, 4'b0010, 2'd1, "ptr_zero");
      step(0, 4'b0000, 1, 0, 4'b0000, 2'd0, "ptr_zero_idle");
      // Ready is ignored in IDLE
      step(0, 4'b0000, 1, 0, 4'b0000, 2'd0, "idle_ready");
      step(0, 4'b1000, 1, 1, 4'b1000, 2'd3, "idle_grant");
      step(0, 4'b0000, 1, 0, 4'b0000, 2'd0, "final_idle");

      for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
      if (q.size() > 0) chk("drain_timeout", 8'(q.size()), 8'd0);
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_grant_arbiter.md
RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 The block SHALL have parameter NINPUTS, default 4, the number of requesters (2..16).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset sampled on the clk rising edge.
REQ-004 The block SHALL have port req, input, NINPUTS, the per-requester request (bit i = requester i).
REQ-005 The block SHALL have port grant, output, NINPUTS, a registered one-hot grant that drives the sel of the downstream one-hot AND-OR data mux.
REQ-006 The block SHALL have port grant_valid, output, 1, asserted when grant holds a live winner.
REQ-007 The block SHALL have port grant_ready, input, 1, asserted by the downstream consumer to accept the current grant.
REQ-008 The block SHALL have port grant_idx, output, clog2(NINPUTS), the binary index of the one-hot grant bit.

Function
REQ-009 The two states SHALL be IDLE (grant_valid=0) and HOLD (grant_valid=1).
REQ-010 In IDLE with any req bit set, the winner SHALL be chosen, grant SHALL be registered, and the state SHALL move to HOLD on the next edge (1-cycle latency req->grant_valid).
REQ-011 The winner SHALL be the first set req bit at or above the one-hot priority pointer, searching upward with wrap-around from bit NINPUTS-1 to bit 0.
REQ-012 In HOLD, grant and grant_idx SHALL stay stable until grant_ready=1, even if req of the winner deasserts (no grant withdrawal).
REQ-013 On accept (HOLD and grant_ready=1), the pointer SHALL rotate to the bit immediately above the accepted winner, wrapping NINPUTS-1 -> 0.
REQ-014 On accept with any req bit set (winner excluded by the rotated pointer unless it is the only requester), a new winner SHALL be registered on the same edge and the state SHALL remain HOLD, giving back-to-back grants with no bubble.
REQ-015 On accept with req all zero, the state SHALL return to IDLE with grant=0 and grant_valid=0.
REQ-016 In IDLE with req=0, the state, pointer and outputs SHALL remain unchanged.
REQ-017 grant SHALL be all-zero whenever grant_valid=0 and exactly one-hot whenever grant_valid=1.
REQ-018 grant_ready SHALL be ignored while in IDLE.
REQ-019 grant_idx SHALL equal the encoded position of grant and SHALL be 0 when grant=0.

Reset
REQ-020 On reset=1 at a clk edge: the state SHALL be IDLE, grant=0, grant_idx=0, grant_valid=0, and the pointer SHALL be one-hot at bit 0.
REQ-021 Reset SHALL override all other inputs, including reset asserted mid-HOLD, and SHALL drop any pending grant without requiring an accept.
REQ-022 On the first edge after reset deasserts, the block SHALL arbitrate normally from pointer bit 0.

Structure
REQ-023 The state encoding constants (IDLE, HOLD) and the index-width helper SHALL live in the shared processor package.
REQ-024 The combinational pointer-relative one-hot pick SHALL be the sub-module rr_priority_pick, with inputs req[NINPUTS] and ptr[NINPUTS] and output pick[NINPUTS].
REQ-025 State, pointer, grant and grant_idx SHALL all be flops in the top; no output SHALL be combinational from req.

Verification (NINPUTS=4)
REQ-026 After reset, req=0101 with ready held 0 -> cycle+1 grant=0001, valid=1, and the grant holds for 5 cycles.
REQ-027 With req=1111 and ready=1 continuously -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles with no bubble.
REQ-028 While granted 0100, req drops to 0000 and ready=0 for 3 cycles -> grant stays 0100 and valid stays 1; when ready=1 -> next cycle valid=0, grant=0.
REQ-029 With the pointer at bit 3 (after accepting 0100), req=0011 -> grant=0001 (wrap-around), grant_idx=0.
REQ-030 Reset asserted during HOLD with grant=0010 -> next cycle valid=0, grant=0; then req=0010 -> grant=0010 from pointer 0.
REQ-031 A checker SHALL confirm on every cycle that grant is one-hot or zero, that grant is stable while valid is high and ready is low, and that grant_idx matches grant.
